spi_host_cmd_arbiter: RTL and testbench
=======================================

Name: spi_host_cmd_arbiter

Overview:
Shares one spi_host command port between NumReq independent requesters, such as firmware mailboxes or DMA engines. Each requester submits command segments (csid, len, speed, direction, csaat). Arbitration is round-robin. Once a requester's segment carries csaat=1, the grant is locked to that requester so a multi-segment chip-select transaction is never interleaved with another requester's traffic. A lock timeout guards against a requester that stalls mid-transaction. The block sits between the requesters and the spi_host command-queue write path.

Parameters:
NumReq, 4, number of requesters (>=1)
NumCS, 1, chip selects on the shared spi_host
CSW, max(1,$clog2(NumCS)), csid width
LenW, 20, segment length field width
LockTimeout, 1024, idle cycles allowed in Locked before forced release (>=2)

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
sw_rst_i  in  1  synchronous soft reset, highest priority
req_valid_i  in  NumReq  per-requester segment valid
req_cmd_i  in  NumReq x seg_cmd_t  per-requester segment
req_ready_o  out  NumReq  one-cycle accept pulse, one-hot
cmd_valid_o  out  1  segment valid towards spi_host
cmd_o  out  seg_cmd_t  registered segment
cmd_ready_i  in  1  spi_host can accept (~command_busy)
gnt_id_o  out  max(1,$clog2(NumReq))  index of the current or last grantee
locked_o  out  1  grant locked (CS held across segments)
err_lock_timeout_o  out  1  one-cycle pulse on forced lock release

Behaviour:
- Reset (async or sw_rst_i): state=Idle; all outputs 0; rr_ptr=0; lock timer=0; cmd_o='0.
- Reset mid-operation: any captured-but-unissued segment is dropped. The requester is not re-notified because its req_ready_o pulse already occurred.
- States are Idle, Issue, Locked.
- Idle:
  - Winner = first index i with req_valid_i[i], scanning from rr_ptr upward and wrapping.
  - If a winner exists: capture req_cmd_i[winner] into cmd_o, pulse req_ready_o[winner], set gnt_id_o=winner, go to Issue.
  - Otherwise stay in Idle.
- Issue:
  - cmd_valid_o=1. cmd_o is held stable until cmd_valid_o & cmd_ready_i.
  - On the handshake, if cmd_o.csaat=1: go to Locked, locked_o=1, timer=0.
  - On the handshake, if csaat=0: go to Idle, locked_o=0, rr_ptr=(gnt_id_o+1) mod NumReq.
  - req_ready_o is all zero in this state.
- Locked:
  - Only requester gnt_id_o is eligible. Other requests are ignored and their valids must stay asserted.
  - If the owner asserts valid: capture, pulse req_ready_o[owner], timer=0, go to Issue. locked_o stays 1 until a csaat=0 segment completes in Issue.
  - If the owner's valid is low: timer++.
  - When timer==LockTimeout-1 with the owner's valid still low: pulse err_lock_timeout_o, clear locked_o, advance rr_ptr past the owner, go to Idle. No segment is issued.
  - The owner asserting valid in the timeout cycle wins: the segment is accepted and no error is raised.
- Latency: request to cmd_valid_o is 1 cycle. Peak throughput is one segment per 2 cycles when cmd_ready_i is held high.
- The timer counts only in Locked. Its width is $clog2(LockTimeout) and it never wraps.
- Segment contents are passed unmodified. Validation of csid, speed and direction remains the job of spi_host.
- NumReq=1: the arbitration logic collapses and locking still applies.
- A cmd_ready_i stall of any length in Issue is legal and does not count toward the timeout.

Decomposition:
- Package spi_host_arb_pkg holds:
  - seg_cmd_t packed struct {csid[CSW], len[LenW], speed[2], direction[2], csaat}, where speed and direction reuse the spi_host command encodings.
  - arb_state_e {Idle, Issue, Locked}.
- Sub-module spi_host_arb_rr is a combinational rotating priority picker: inputs valid vector and rr_ptr; outputs winner index and any_valid.
- The FSM, capture register and timer live in the top module.

Test Plan:
- Round-robin fairness: all four valids held high, all segments with csaat=0, cmd_ready_i=1 -> grants 0,1,2,3,0 on cycles 1,3,5,7,9; each req_ready_o pulses exactly once per grant.
- Lock hold: req1 sends csaat=1 len=8, then csaat=0 len=16, while req0 and req2 stay valid -> both req1 segments are issued back-to-back; locked_o=1 between them; the next grant goes to req2.
- Backpressure: cmd_ready_i=0 for 50 cycles in Issue -> cmd_o is stable, cmd_valid_o=1, no req_ready_o pulses, no timeout; the segment is issued on the cycle cmd_ready_i rises.
- Lock timeout with LockTimeout=16: req3 sends csaat=1 then goes silent -> err_lock_timeout_o pulses 16 cycles after the handshake; locked_o drops; req0 is granted next.
- sw_rst_i asserted in Issue with cmd_ready_i=0 -> next cycle cmd_valid_o=0, locked_o=0, state=Idle; the first grant after release goes to req0.
- Async reset asserted mid-Locked -> all outputs 0 immediately; after release, behaviour is identical to power-up.

Source files
------------

// File: rtl/spi_host_arb_pkg.sv
// rtl/spi_host_arb_pkg.sv - shared types for the spi_host command arbiter
// Purpose: segment command struct, arbiter state encoding, index-width helper.
// Ports: none (package).
package spi_host_arb_pkg;

  localparam int NumCS = 1;
  localparam int CSW   = (NumCS > 1) ? $clog2(NumCS) : 1;
  localparam int LenW  = 20;

  // speed and direction use the spi_host command-register encodings unchanged
  typedef struct packed {
    logic [CSW-1:0]  csid;
    logic [LenW-1:0] len;
    logic [1:0]      speed;
    logic [1:0]      direction;
    logic            csaat;
  } seg_cmd_t;

  typedef enum logic [1:0] {
    Idle,
    Issue,
    Locked
  } arb_state_e;

  // index width that stays at least one bit for a single requester
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_host_cmd_arbiter_if.sv
// rtl/spi_host_cmd_arbiter_if.sv - requester and spi_host command bus bundle
// Purpose: groups the per-requester segment handshake and the shared command
//          port. Signal names are from the arbiter's point of view.
// Ports (signals):
//   req_valid_i/req_cmd_i/req_ready_o : NumReq requester segment handshakes
//   cmd_valid_o/cmd_o/cmd_ready_i     : segment towards the spi_host command queue
// Modports: slave = arbiter side, master = requesters plus spi_host side.
interface spi_host_cmd_arbiter_if
  import spi_host_arb_pkg::*;
#(
  parameter int NumReq = 4
) ();

  logic     [NumReq-1:0] req_valid_i;
  seg_cmd_t [NumReq-1:0] req_cmd_i;
  logic     [NumReq-1:0] req_ready_o;
  logic                  cmd_valid_o;
  seg_cmd_t              cmd_o;
  logic                  cmd_ready_i;

  modport slave (
    input  req_valid_i, req_cmd_i, cmd_ready_i,
    output req_ready_o, cmd_valid_o, cmd_o
  );

  modport master (
    output req_valid_i, req_cmd_i, cmd_ready_i,
    input  req_ready_o, cmd_valid_o, cmd_o
  );

endinterface

// File: rtl/spi_host_arb_rr.sv
// rtl/spi_host_arb_rr.sv - combinational rotating-priority picker
// Purpose: returns the first set bit of i_valid at or above i_ptr, wrapping to
//          the lowest set bit when nothing at or above i_ptr is set.
// Ports:
//   i_valid     : request vector
//   i_ptr       : index with highest priority this cycle
//   o_winner    : chosen index (0 when o_any_valid is low)
//   o_any_valid : at least one request present
module spi_host_arb_rr
  import spi_host_arb_pkg::*;
#(
  parameter  int NumReq = 4,
  localparam int IdxW   = idx_w(NumReq)
) (
  input  logic [NumReq-1:0] i_valid,
  input  logic [IdxW-1:0]   i_ptr,
  output logic [IdxW-1:0]   o_winner,
  output logic              o_any_valid
);

  logic [IdxW-1:0] w_lo;
  logic [IdxW-1:0] w_hi;
  logic            w_hit_hi;

  // Descending scan: the last hit is the lowest index, once over the whole
  // vector (wrap candidate) and once restricted to indices >= i_ptr.
  always_comb begin
    w_lo        = '0;
    w_hi        = '0;
    w_hit_hi    = 1'b0;
    o_any_valid = 1'b0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (i_valid[i]) begin
        o_any_valid = 1'b1;
        w_lo        = IdxW'(i);
        if (IdxW'(i) >= i_ptr) begin
          w_hit_hi = 1'b1;
          w_hi     = IdxW'(i);
        end
      end
    end
  end

  assign o_winner = w_hit_hi ? w_hi : w_lo;

endmodule

// File: rtl/spi_host_cmd_arbiter.sv
// rtl/spi_host_cmd_arbiter.sv - round-robin spi_host command arbiter with CS lock
// Purpose: shares one spi_host command port among NumReq requesters. A segment
//          with csaat=1 locks the grant to its owner until a csaat=0 segment
//          completes or the owner stays silent for LockTimeout cycles.
// Ports:
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   sw_rst_i           : synchronous soft reset, overrides everything
//   bus (slave)        : requester handshakes and spi_host command port
//   gnt_id_o           : current or last grantee
//   locked_o           : grant locked, chip select held across segments
//   err_lock_timeout_o : one-cycle pulse when a lock is forcibly released
module spi_host_cmd_arbiter
  import spi_host_arb_pkg::*;
#(
  parameter  int NumReq      = 4,
  parameter  int LockTimeout = 1024,
  localparam int IdxW        = idx_w(NumReq),
  localparam int TmrW        = $clog2(LockTimeout)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  sw_rst_i,
  spi_host_cmd_arbiter_if.slave bus,
  output logic [IdxW-1:0]       gnt_id_o,
  output logic                  locked_o,
  output logic                  err_lock_timeout_o
);

  arb_state_e      r_state;
  arb_state_e      w_state_nxt;
  seg_cmd_t        r_cmd;
  logic [IdxW-1:0] r_gnt;
  logic [IdxW-1:0] r_rr_ptr;
  logic [TmrW-1:0] r_timer;
  logic            r_locked;
  logic            r_err;

  logic [IdxW-1:0] w_winner;
  logic [IdxW-1:0] w_acc_idx;
  logic [IdxW-1:0] w_gnt_inc;
  logic            w_any_valid;
  logic            w_owner_valid;
  logic            w_accept;
  logic            w_hs;
  logic            w_timeout;

  spi_host_arb_rr #(
    .NumReq (NumReq)
  ) u_rr (
    .i_valid     (bus.req_valid_i),
    .i_ptr       (r_rr_ptr),
    .o_winner    (w_winner),
    .o_any_valid (w_any_valid)
  );

  assign w_owner_valid = bus.req_valid_i[r_gnt];
  // while locked only the owner may be accepted; otherwise the picker decides
  assign w_acc_idx = (r_state == Locked) ? r_gnt : w_winner;
  assign w_accept  = ((r_state == Idle) && w_any_valid) ||
                     ((r_state == Locked) && w_owner_valid);
  assign w_hs      = (r_state == Issue) && bus.cmd_ready_i;
  // an owner request in the final cycle takes precedence over the timeout
  assign w_timeout = (r_state == Locked) && !w_owner_valid &&
                     (r_timer == TmrW'(LockTimeout - 1));
  assign w_gnt_inc = (r_gnt == IdxW'(NumReq - 1)) ? '0 : r_gnt + 1'b1;

  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= Idle;
    end else if (sw_rst_i) begin
      r_state <= Idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      Idle:    if (w_accept) w_state_nxt = Issue;
      Issue:   if (w_hs) w_state_nxt = r_cmd.csaat ? Locked : Idle;
      Locked: begin
        if (w_accept)       w_state_nxt = Issue;
        else if (w_timeout) w_state_nxt = Idle;
      end
      default: w_state_nxt = Idle;
    endcase
  end

  // outputs; the accept pulse is masked while any reset is active
  always_comb begin
    bus.cmd_valid_o = (r_state == Issue);
    bus.req_ready_o = '0;
    if (w_accept && rst_ni && !sw_rst_i) begin
      bus.req_ready_o[w_acc_idx] = 1'b1;
    end
  end

  // capture register, lock flag, round-robin pointer and lock timer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cmd    <= '0;
      r_gnt    <= '0;
      r_rr_ptr <= '0;
      r_timer  <= '0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
    end else if (sw_rst_i) begin
      r_cmd    <= '0;
      r_gnt    <= '0;
      r_rr_ptr <= '0;
      r_timer  <= '0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cmd <= bus.req_cmd_i[w_acc_idx];
        r_gnt <= w_acc_idx;
      end
      if (w_hs)           r_locked <= r_cmd.csaat;
      else if (w_timeout) r_locked <= 1'b0;
      if ((w_hs && !r_cmd.csaat) || w_timeout) r_rr_ptr <= w_gnt_inc;
      // counts only silent Locked cycles; cleared on any exit or owner request
      r_timer <= ((r_state == Locked) && !w_accept && !w_timeout) ?
                 r_timer + 1'b1 : '0;
      r_err   <= w_timeout;
    end
  end

  assign bus.cmd_o          = r_cmd;
  assign gnt_id_o           = r_gnt;
  assign locked_o           = r_locked;
  assign err_lock_timeout_o = r_err;

endmodule

// File: tb/tb_spi_host_cmd_arbiter.sv
// tb/tb_spi_host_cmd_arbiter.sv - self-checking bench for spi_host_cmd_arbiter
module tb_spi_host_cmd_arbiter;
  import spi_host_arb_pkg::*;

  localparam int N = 4;
  localparam int T = 16;

  logic       clk_i    = 1'b0;
  logic       rst_ni   = 1'b0;
  logic       sw_rst_i = 1'b0;
  logic [1:0] gnt_id_o;
  logic       locked_o;
  logic       err_lock_timeout_o;

  int n_chk  = 0;
  int n_fail = 0;

  spi_host_cmd_arbiter_if #(.NumReq(N)) bus ();

  spi_host_cmd_arbiter #(
    .NumReq      (N),
    .LockTimeout (T)
  ) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .sw_rst_i           (sw_rst_i),
    .bus                (bus),
    .gnt_id_o           (gnt_id_o),
    .locked_o           (locked_o),
    .err_lock_timeout_o (err_lock_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic seg_cmd_t mk(input int len, input bit csaat);
    seg_cmd_t s;
    s.csid      = '0;
    s.len       = LenW'(len);
    s.speed     = 2'(len);
    s.direction = 2'(len >> 2);
    s.csaat     = csaat;
    return s;
  endfunction

  // ---------------- behavioural model ----------------
  // m_have: a captured segment is waiting for spi_host
  // m_locked: some requester owns the chip select
  int       m_ptr    = 0;
  int       m_gnt    = 0;
  int       m_idle   = 0;
  bit       m_locked = 0;
  bit       m_have   = 0;
  bit       m_err    = 0;
  seg_cmd_t m_seg    = '0;

  task automatic m_reset();
    m_ptr = 0; m_gnt = 0; m_idle = 0;
    m_locked = 0; m_have = 0; m_err = 0; m_seg = '0;
  endtask

  function automatic int m_pick();
    for (int k = 0; k < N; k++)
      if (bus.req_valid_i[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] one = 1;
    int w;
    if (!rst_ni || sw_rst_i || m_have) return '0;
    if (m_locked) return bus.req_valid_i[m_gnt] ? (one << m_gnt) : '0;
    w = m_pick();
    return (w < 0) ? '0 : (one << w);
  endfunction

  always @(posedge clk_i) begin
    int w;
    if (!rst_ni || sw_rst_i) begin
      m_reset();
    end else begin
      m_err = 0;
      if (m_have) begin
        if (bus.cmd_ready_i) begin
          m_have = 0;
          if (m_seg.csaat) begin
            m_locked = 1; m_idle = 0;
          end else begin
            m_locked = 0; m_ptr = (m_gnt + 1) % N;
          end
        end
      end else if (m_locked) begin
        if (bus.req_valid_i[m_gnt]) begin
          m_seg = bus.req_cmd_i[m_gnt]; m_have = 1; m_idle = 0;
        end else if (m_idle == T - 1) begin
          m_err = 1; m_locked = 0; m_idle = 0; m_ptr = (m_gnt + 1) % N;
        end else begin
          m_idle++;
        end
      end else begin
        w = m_pick();
        if (w >= 0) begin
          m_gnt = w; m_seg = bus.req_cmd_i[w]; m_have = 1;
        end
      end
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      chk("cmp_rst_valid", bus.cmd_valid_o, 0);
      chk("cmp_rst_cmd", bus.cmd_o, 0);
      chk("cmp_rst_ready", bus.req_ready_o, 0);
      chk("cmp_rst_locked", locked_o, 0);
    end else begin
      chk("cmp_cmd_valid", bus.cmd_valid_o, m_have);
      chk("cmp_cmd", bus.cmd_o, m_seg);
      chk("cmp_gnt", gnt_id_o, m_gnt);
      chk("cmp_locked", locked_o, m_locked);
      chk("cmp_err", err_lock_timeout_o, m_err);
      chk("cmp_ready", bus.req_ready_o, m_ready());
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  int rr_gnt[5] = '{0, 1, 2, 3, 0};
  int rr_rdy[5] = '{1, 2, 4, 8, 1};

  initial begin
    bus.req_valid_i = '0;
    bus.req_cmd_i   = '0;
    bus.cmd_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_valid", bus.cmd_valid_o, 0);
    chk("reset_gnt", gnt_id_o, 0);
    chk("reset_err", err_lock_timeout_o, 0);
    tick();
    rst_ni = 1'b1;
    tick();

    // round-robin fairness
    for (int i = 0; i < N; i++) bus.req_cmd_i[i] = mk(32'h100 + i, 1'b0);
    bus.req_valid_i = 4'hF;
    for (int c = 0; c < 10; c++) begin
      if (c == 9) bus.req_valid_i = '0;
      @(negedge clk_i);
      if (c % 2 == 1) begin
        chk("rr_cmd_valid", bus.cmd_valid_o, 1);
        chk("rr_gnt", gnt_id_o, rr_gnt[c / 2]);
        chk("rr_len", bus.cmd_o.len, 32'h100 + rr_gnt[c / 2]);
      end else begin
        chk("rr_ready", bus.req_ready_o, rr_rdy[c / 2]);
      end
      tick();
    end

    // lock hold: req1 two segments, req0/req2 waiting
    bus.req_cmd_i[1] = mk(8, 1'b1);
    bus.req_valid_i  = 4'b0010;
    @(negedge clk_i); chk("lk_ready_a", bus.req_ready_o, 4'b0010);
    tick();
    bus.req_cmd_i[1] = mk(16, 1'b0);
    bus.req_valid_i  = 4'b0111;
    @(negedge clk_i);
    chk("lk_issue_a", bus.cmd_valid_o, 1);
    chk("lk_len_a", bus.cmd_o.len, 8);
    chk("lk_csaat_a", bus.cmd_o.csaat, 1);
    tick();
    @(negedge clk_i);
    chk("lk_locked", locked_o, 1);
    chk("lk_ready_b", bus.req_ready_o, 4'b0010);
    tick();
    bus.req_valid_i = 4'b0101;
    @(negedge clk_i);
    chk("lk_len_b", bus.cmd_o.len, 16);
    chk("lk_locked_b", locked_o, 1);
    tick();
    @(negedge clk_i);
    chk("lk_unlocked", locked_o, 0);
    chk("lk_next_req2", bus.req_ready_o, 4'b0100);
    tick();
    bus.req_valid_i = '0;
    @(negedge clk_i); chk("lk_gnt2", gnt_id_o, 2);
    tick();

    // backpressure on req3's segment
    bus.req_cmd_i[3] = mk(32'h12345, 1'b0);
    bus.req_valid_i  = 4'b1000;
    bus.cmd_ready_i  = 1'b0;
    @(negedge clk_i); chk("bp_ready", bus.req_ready_o, 4'b1000);
    tick();
    bus.req_valid_i = 4'hF;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk_i);
      chk("bp_hold_valid", bus.cmd_valid_o, 1);
      chk("bp_hold_len", bus.cmd_o.len, 32'h12345);
      chk("bp_no_ready", bus.req_ready_o, 0);
      chk("bp_no_err", err_lock_timeout_o, 0);
      tick();
    end
    bus.cmd_ready_i = 1'b1;
    bus.req_valid_i = '0;
    @(negedge clk_i); chk("bp_issue", bus.cmd_valid_o, 1);
    tick();
    @(negedge clk_i); chk("bp_done", bus.cmd_valid_o, 0);
    tick();

    // lock timeout: req3 locks then goes silent, req0 waits
    bus.req_cmd_i[3] = mk(32'h77, 1'b1);
    bus.req_cmd_i[0] = mk(32'h55, 1'b1);
    bus.req_valid_i  = 4'b1000;
    @(negedge clk_i); chk("to_ready3", bus.req_ready_o, 4'b1000);
    tick();
    bus.req_valid_i = 4'b0001;
    @(negedge clk_i); chk("to_issue", bus.cmd_valid_o, 1);
    for (int k = 0; k < T; k++) begin
      tick();
      @(negedge clk_i);
      chk("to_wait_err", err_lock_timeout_o, 0);
      chk("to_wait_locked", locked_o, 1);
      chk("to_wait_ready", bus.req_ready_o, 0);
    end
    tick();
    @(negedge clk_i);
    chk("to_err", err_lock_timeout_o, 1);
    chk("to_unlocked", locked_o, 0);
    chk("to_next_req0", bus.req_ready_o, 4'b0001);
    tick();
    bus.req_valid_i = '0;
    @(negedge clk_i);
    chk("to_err_pulse", err_lock_timeout_o, 0);
    chk("to_gnt0", gnt_id_o, 0);
    // req0 now holds the lock and answers in the very last allowed cycle
    for (int k = 0; k < T - 1; k++) begin
      tick();
      @(negedge clk_i); chk("to2_wait", bus.req_ready_o, 0);
    end
    tick();
    bus.req_cmd_i[0] = mk(32'h66, 1'b0);
    bus.req_valid_i  = 4'b0001;
    @(negedge clk_i); chk("to2_owner_wins", bus.req_ready_o, 4'b0001);
    tick();
    bus.req_valid_i = '0;
    @(negedge clk_i);
    chk("to2_no_err", err_lock_timeout_o, 0);
    chk("to2_len", bus.cmd_o.len, 32'h66);
    chk("to2_locked", locked_o, 1);
    tick();
    @(negedge clk_i); chk("to2_unlocked", locked_o, 0);
    tick();

    // soft reset while a segment is stalled in Issue
    bus.req_valid_i = 4'b0100;
    bus.cmd_ready_i = 1'b0;
    @(negedge clk_i); chk("sw_ready2", bus.req_ready_o, 4'b0100);
    tick();
    bus.req_valid_i = '0;
    sw_rst_i        = 1'b1;
    @(negedge clk_i); chk("sw_in_issue", bus.cmd_valid_o, 1);
    tick();
    sw_rst_i        = 1'b0;
    bus.cmd_ready_i = 1'b1;
    bus.req_valid_i = 4'hF;
    @(negedge clk_i);
    chk("sw_dropped", bus.cmd_valid_o, 0);
    chk("sw_cmd_clear", bus.cmd_o, 0);
    chk("sw_first_req0", bus.req_ready_o, 4'b0001);
    tick();
    bus.req_valid_i = '0;
    @(negedge clk_i); chk("sw_gnt0", gnt_id_o, 0);
    tick();

    // asynchronous reset in the middle of a lock
    bus.req_cmd_i[1] = mk(32'h99, 1'b1);
    bus.req_valid_i  = 4'b0010;
    @(negedge clk_i); chk("ar_ready1", bus.req_ready_o, 4'b0010);
    tick();
    bus.req_valid_i = '0;
    tick();
    @(negedge clk_i); chk("ar_locked", locked_o, 1);
    tick();
    bus.req_valid_i = 4'b0011;
    #1;
    chk("ar_pre_ready", bus.req_ready_o, 4'b0010);
    rst_ni = 1'b0;
    #1;
    chk("ar_locked0", locked_o, 0);
    chk("ar_ready0", bus.req_ready_o, 0);
    chk("ar_cmd0", bus.cmd_o, 0);
    chk("ar_gnt0", gnt_id_o, 0);
    bus.req_valid_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    bus.req_valid_i = 4'hF;
    @(negedge clk_i); chk("ar_first_req0", bus.req_ready_o, 4'b0001);
    tick();
    bus.req_valid_i = '0;
    @(negedge clk_i); chk("ar_gnt_req0", gnt_id_o, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
